// File: rtl/mux_m_pkg.sv
// Shared constants for the mux_m steering element: legal pipeline depths
// and the default data width.
package mux_m_pkg;

  localparam int LAT_COMB = 0;
  localparam int LAT_ONE  = 1;
  localparam int LAT_TWO  = 2;
  localparam int MUX_M_W  = 5;

endpackage

// File: rtl/mux_m_if.sv
// Bundle of the selector's data, select and valid signals. The master side
// drives the two candidates, the select and the valid flag; the slave side
// (the mux itself) returns the pipelined and combinational results.
interface mux_m_if import mux_m_pkg::*; #(
  parameter int WIDTH = MUX_M_W
) ();

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             s;
  logic             in_valid;
  logic [WIDTH-1:0] y;
  logic             out_valid;
  logic [WIDTH-1:0] y_comb;

  modport master (
    output a, b, s, in_valid,
    input  y, out_valid, y_comb
  );

  modport slave (
    input  a, b, s, in_valid,
    output y, out_valid, y_comb
  );

endinterface

// File: rtl/mux_m_stage.sv
// One register stage of the mux output pipeline. Data and its valid flag
// move together every cycle; there is no load enable, the valid bit is just
// a sideband tag. Synchronous active-low reset clears the stage.
module mux_m_stage import mux_m_pkg::*; #(
  parameter int               WIDTH     = MUX_M_W,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data_i,
  input  logic             valid_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o
);

  logic [WIDTH-1:0] data_d, data_q;
  logic             valid_d, valid_q;

  // Next-state: pass the incoming pair through, or the reset pair when rst_n is low.
  always_comb begin
    data_d  = data_i;
    valid_d = valid_i;
    if (!rst_n) begin
      data_d  = RESET_VAL;
      valid_d = 1'b0;
    end
  end

  // Stage register, loaded on every rising edge.
  always_ff @(posedge clk) begin
    data_q  <= data_d;
    valid_q <= valid_d;
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/mux_m.sv
// Parameterised 2:1 data selector. y_comb is the raw selection; y/out_valid
// are the selection and in_valid carried through LATENCY register stages
// (0, 1 or 2). With LATENCY=0 the pipeline collapses to wires.
module mux_m import mux_m_pkg::*; #(
  parameter int               WIDTH     = MUX_M_W,
  parameter int               LATENCY   = LAT_ONE,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic       clk,
  input  logic       rst_n,
  mux_m_if.slave     bus
);

  logic [WIDTH-1:0] selData;
  logic [WIDTH-1:0] chainData  [0:LATENCY];
  logic             chainValid [0:LATENCY];

  // Selection: b when s is high, a otherwise.
  always_comb begin
    selData = bus.a;
    if (bus.s) begin
      selData = bus.b;
    end
  end

  assign bus.y_comb    = selData;
  assign chainData[0]  = selData;
  assign chainValid[0] = bus.in_valid;

  // Shift chain: stage i takes entry i and produces entry i+1.
  for (genvar i = 0; i < LATENCY; i++) begin : gStage
    mux_m_stage #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) uStage (
      .clk     (clk),
      .rst_n   (rst_n),
      .data_i  (chainData[i]),
      .valid_i (chainValid[i]),
      .data_o  (chainData[i+1]),
      .valid_o (chainValid[i+1])
    );
  end

  // A purely combinational build has no registers, so clk and rst_n go unused.
  if (LATENCY == LAT_COMB) begin : gComb
    logic unusedClkRst;
    assign unusedClkRst = clk ^ rst_n;
  end

  assign bus.y         = chainData[LATENCY];
  assign bus.out_valid = chainValid[LATENCY];

endmodule

// File: tb/tb_mux_m.sv
// Directed bench for mux_m: three copies (LATENCY 0, 1, 2) share one stimulus
// stream. Expected values are hand constants plus a tiny two-deep shift model.
module tb_mux_m;
  import mux_m_pkg::*;

  localparam logic [4:0] A1 = 5'b10110;
  localparam logic [4:0] B1 = 5'b11001;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  int checkCount = 0;
  int passCount  = 0;

  logic [4:0] m1d = '0, m2d = '0;
  logic       m1v = 1'b0, m2v = 1'b0;
  logic [4:0] expSel;

  mux_m_if #(.WIDTH(5)) bus0 ();
  mux_m_if #(.WIDTH(5)) bus1 ();
  mux_m_if #(.WIDTH(5)) bus2 ();

  mux_m #(.WIDTH(5), .LATENCY(LAT_COMB)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  mux_m #(.WIDTH(5), .LATENCY(LAT_ONE))  dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  mux_m #(.WIDTH(5), .LATENCY(LAT_TWO))  dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  // Free-running clock, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  // Counts one comparison and reports it when observed differs from expected.
  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Drives one cycle of inputs on the falling edge, checks the combinational
  // outputs, then checks the registered outputs just after the rising edge.
  task automatic applyStimulus(input logic rstIn, input logic [4:0] aIn, input logic [4:0] bIn,
                               input logic sIn, input logic vIn);
    @(negedge clk);
    rst_n = rstIn;
    bus0.a = aIn; bus0.b = bIn; bus0.s = sIn; bus0.in_valid = vIn;
    bus1.a = aIn; bus1.b = bIn; bus1.s = sIn; bus1.in_valid = vIn;
    bus2.a = aIn; bus2.b = bIn; bus2.s = sIn; bus2.in_valid = vIn;
    expSel = sIn ? bIn : aIn;
    #1;
    checkOutput("ycomb0", 64'(bus0.y_comb), 64'(expSel));
    checkOutput("ycomb1", 64'(bus1.y_comb), 64'(expSel));
    checkOutput("ycomb2", 64'(bus2.y_comb), 64'(expSel));
    checkOutput("y0", 64'(bus0.y), 64'(expSel));
    checkOutput("ov0", 64'(bus0.out_valid), 64'(vIn));
    @(posedge clk);
    if (!rstIn) begin
      m2d = '0; m2v = 1'b0; m1d = '0; m1v = 1'b0;
    end else begin
      m2d = m1d; m2v = m1v; m1d = expSel; m1v = vIn;
    end
    #1;
    checkOutput("y1", 64'(bus1.y), 64'(m1d));
    checkOutput("ov1", 64'(bus1.out_valid), 64'(m1v));
    checkOutput("y2", 64'(bus2.y), 64'(m2d));
    checkOutput("ov2", 64'(bus2.out_valid), 64'(m2v));
  endtask

  // Main directed sequence.
  initial begin
    bus0.a = A1; bus0.b = B1; bus0.s = 1'b1; bus0.in_valid = 1'b1;
    bus1.a = A1; bus1.b = B1; bus1.s = 1'b1; bus1.in_valid = 1'b1;
    bus2.a = A1; bus2.b = B1; bus2.s = 1'b1; bus2.in_valid = 1'b1;

    // Reset held for two edges with s=1.
    applyStimulus(1'b0, A1, B1, 1'b1, 1'b1);
    applyStimulus(1'b0, A1, B1, 1'b1, 1'b1);
    checkOutput("rstY1", 64'(bus1.y), 64'h0);
    checkOutput("rstOv1", 64'(bus1.out_valid), 64'h0);
    checkOutput("rstY2", 64'(bus2.y), 64'h0);
    checkOutput("rstYcomb", 64'(bus1.y_comb), 64'h19);

    // Select a, then b.
    applyStimulus(1'b1, A1, B1, 1'b0, 1'b1);
    checkOutput("selA_y1", 64'(bus1.y), 64'h16);
    checkOutput("selA_ov1", 64'(bus1.out_valid), 64'h1);
    checkOutput("selA_ov2", 64'(bus2.out_valid), 64'h0);
    applyStimulus(1'b1, A1, B1, 1'b1, 1'b1);
    checkOutput("selB_y1", 64'(bus1.y), 64'h19);
    checkOutput("selB_y2", 64'(bus2.y), 64'h16);
    checkOutput("selB_ov2", 64'(bus2.out_valid), 64'h1);

    // s toggling every cycle, with one invalid slot.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, A1, B1, i[0], (i != 2));
    end
    checkOutput("tglY1", 64'(bus1.y), 64'h19);
    checkOutput("tglY2", 64'(bus2.y), 64'h16);

    // One-edge reset in the middle of the stream.
    applyStimulus(1'b0, A1, B1, 1'b0, 1'b1);
    checkOutput("midY2", 64'(bus2.y), 64'h0);
    checkOutput("midOv2", 64'(bus2.out_valid), 64'h0);
    checkOutput("midOv1", 64'(bus1.out_valid), 64'h0);
    applyStimulus(1'b1, A1, B1, 1'b0, 1'b1);
    checkOutput("relOv2a", 64'(bus2.out_valid), 64'h0);
    applyStimulus(1'b1, A1, B1, 1'b1, 1'b0);
    checkOutput("relOv2b", 64'(bus2.out_valid), 64'h1);
    checkOutput("relY2b", 64'(bus2.y), 64'h16);
    checkOutput("relOv1b", 64'(bus1.out_valid), 64'h0);

    // Combinational build: zero latency, reset has no effect.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(i[1], 5'b00000, 5'b11111, i[0], i[0]);
    end
    checkOutput("combY0", 64'(bus0.y), 64'h1f);

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

  // Guard against a hung run.
  initial begin
    #20000;
    $display("[TB] FAIL timeout observed=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/mux_m.md
Name: mux_m

Overview:
- Parameterised-width 2:1 data selector with an optional registered output pipeline.
- Output carries `a` when `s`=0 and `b` when `s`=1.
- Used as a generic datapath steering element; default configuration is the 5-bit, one-register-stage variant.
- One clock domain; synchronous, active-low reset.

Parameters:
- WIDTH, 5, data width of `a`, `b`, `y`, `y_comb`; legal range 1..64.
- LATENCY, 1, registered pipeline stages between inputs and `y`/`out_valid`; legal values 0, 1, 2.
- RESET_VAL, 0, value loaded into every data pipeline register on reset (WIDTH bits).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk.
- a  input  WIDTH  data input selected when s=0.
- b  input  WIDTH  data input selected when s=1.
- s  input  1  select: 0 -> a, 1 -> b.
- in_valid  input  1  qualifies a/b/s this cycle.
- y  output  WIDTH  selected data after LATENCY stages.
- out_valid  output  1  in_valid delayed by LATENCY stages.
- y_comb  output  WIDTH  purely combinational selection, always (s ? b : a), no latency.

Behaviour:
- Selection: sel_data = s ? b : a, bitwise for all WIDTH bits. No arithmetic, no width change.
- s of X/Z is not supported; the bench drives only 0/1.
- y_comb: always equals sel_data in the same cycle, independent of clk, rst_n and in_valid.
- LATENCY=0:
  - y = sel_data combinationally; out_valid = in_valid combinationally.
  - No registers; rst_n has no effect.
- LATENCY=1:
  - On each rising clk with rst_n=1: y_reg <= sel_data; v_reg <= in_valid.
  - y = y_reg, out_valid = v_reg. One-cycle latency.
- LATENCY=2:
  - Two-stage shift of (sel_data, in_valid); y and out_valid reflect inputs sampled two rising edges earlier.
- Data registers load every cycle regardless of in_valid (no enable gating). in_valid is only a sideband flag carried alongside the data.
- Reset:
  - On a rising clk with rst_n=0, every data stage loads RESET_VAL and every valid stage loads 0.
  - After reset, y=RESET_VAL (default 0) and out_valid=0 until data propagates.
  - Reset asserted mid-stream discards all in-flight stages on that edge.
  - The first valid output appears LATENCY edges after the first post-reset edge with in_valid=1.
- Simultaneous change of a, b and s in one cycle: the output reflects the values sampled at that edge; there is no glitch memory and no priority between inputs.
- s toggling every cycle: y alternates between the a and b values sampled on successive edges, delayed by LATENCY.
- No state machine; the pipeline is a pure shift register.

Decomposition:
- Shared package: LATENCY legal-value constants (LAT_COMB=0, LAT_ONE=1, LAT_TWO=2) and a default data width constant MUX_M_W=5.
- One natural sub-module, mux_m_stage: a single register stage of (data WIDTH, valid 1) with synchronous active-low reset to (RESET_VAL, 0).
- mux_m instantiates mux_m_stage LATENCY times via a generate loop; the selector logic lives in the top.

Test Plan:
- Reset: rst_n=0 for 2 cycles with a=5'b10110, b=5'b11001, s=1 -> y=5'b00000, out_valid=0 on the release edge; y_comb=5'b11001 throughout.
- Select a: rst_n=1, a=5'b10110, b=5'b11001, s=0, in_valid=1 -> y_comb=5'b10110 immediately; y=5'b10110 and out_valid=1 one clk later (LATENCY=1).
- Select b: same a/b, s=1 -> y_comb=5'b11001 immediately; y=5'b11001 one clk later.
- Toggle: s inverted every cycle with a=5'b10110, b=5'b11001 -> y alternates 10110/11001, lagging s by exactly one clk; out_valid follows in_valid one clk late.
- Mid-stream reset: stream running at LATENCY=2, assert rst_n=0 for one edge -> both stages cleared; y=0 and out_valid=0 after that edge; the next valid input appears two edges after release.
- Combinational build (LATENCY=0): a=5'b00000, b=5'b11111, s toggled -> y equals y_comb each cycle with zero latency; rst_n has no effect on y.
